clock_work_multi: RTL and testbench
===================================

Name: clock_work_multi

Overview:
Parametrised successor to the 1 Hz timekeeping core. Runs from the system clock with an internal prescaler instead of an external 1 Hz clock, and keeps a packed {hour,min,sec} 24-hour time with synchronous overwrite. Adds N_ALARM independent alarm channels with sticky ring flags, plus second/day strobes for downstream display and date logic.

Parameters:
TICK_DIV, 100000000, clk cycles per second (>=2; benches use 4)
N_ALARM, 2, number of alarm channels (1..8)
SEL_W, max(1,clog2(N_ALARM)), alarm_sel width (localparam, derived)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
time_ow  in  1  load time_in into the time registers
time_in  in  17  {hour[16:12], min[11:6], sec[5:0]}
alarm_wr  in  1  write alarm channel alarm_sel
alarm_sel  in  SEL_W  alarm channel index
alarm_in  in  17  alarm time, same packing as time_in
alarm_en_in  in  1  enable bit written with alarm_in
alarm_ack  in  N_ALARM  per-channel ring clear
time_out  out  17  current time, registered
sec_tick  out  1  one-cycle pulse per second increment
day_pulse  out  1  one-cycle pulse on the 23:59:59->00:00:00 rollover
alarm_ring  out  N_ALARM  sticky ring flags

Behaviour:
- Reset (sync, rst high at a clk edge): time_out=0, prescaler=0, sec_tick=0, day_pulse=0, all alarm times=0, all alarm enables=0, alarm_ring=0. Reset mid-second discards the partial second.
- Prescaler counts 0..TICK_DIV-1. At count==TICK_DIV-1 it wraps to 0, and a tick occurs that cycle. sec_tick is registered: it is high in the same cycle time_out shows the incremented value.
- Increment on tick: sec+1. sec 59->0 carries to min. min 59->0 carries to hour. hour 23->0 sets day_pulse for that one cycle.
- time_ow: time_in loads at the next edge and the prescaler clears to 0, so the next tick follows a full TICK_DIV cycles. time_ow has priority over a coincident tick: no increment, no sec_tick, no day_pulse.
- Overwrite validation, per field: sec>59 loads 0, min>59 loads 0, hour>23 loads 0. Valid fields load unchanged.
- Alarm write: on alarm_wr, channel alarm_sel stores alarm_in (same field validation) and alarm_en_in. alarm_sel>=N_ALARM is ignored. Writing alarm_en_in=0 clears that channel's ring in the same edge.
- Alarm match: evaluated on the next-time value whenever time changes (tick or overwrite). If channel k is enabled and next time equals alarm[k], alarm_ring[k] sets on the same edge time_out updates. The flag holds until alarm_ack[k] is sampled high.
- Set and ack in the same cycle: set wins, ring stays 1.
- An alarm write in the same cycle as a match uses the old alarm value.
- All outputs are registered. No combinational input-to-output paths.

Optional Feature:
TWELVE_HOUR_EN
- Defined: adds outputs hour12[3:0] and pm, registered and updated with time_out.
  - hour 0 -> hour12=12, pm=0
  - hours 1..11 -> hour12=hour, pm=0
  - hour 12 -> hour12=12, pm=1
  - hours 13..23 -> hour12=hour-12, pm=1
  - Reset: hour12=12, pm=0.
- Undefined: the ports do not exist. Behaviour otherwise identical.

Decomposition:
- Package clock_pkg:
  - SEC_W=6, MIN_W=6, HOUR_W=5, TIME_W=17
  - SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23
  - packed struct time_t {hour,min,sec}
  - function validate_time (zeroes out-of-range fields)
- Sub-module tick_prescaler (TICK_DIV; inputs clk, rst, clear; output tick).

Test Plan:
- Reset with TICK_DIV=4 -> time_out=0. First sec_tick after 4 cycles with time_out=17'h00001. day_pulse and alarm_ring stay 0.
- time_ow with time_in=17'b10111_111011_111011 (23:59:59) -> after 4 cycles time_out=0, sec_tick=1 and day_pulse=1 for exactly one cycle.
- time_ow with time_in=17'b10111_111100_000101 (min=60) -> time_out=23:00:05. time_ow asserted on a tick cycle -> no increment, next tick 4 cycles later.
- Write alarm 1 = 00:00:02, enabled; run from 0 -> alarm_ring=2'b10 rises on the edge time_out becomes 2 and holds. alarm_ack[1] coincident with a fresh match keeps it 1. A lone ack clears it.
- Alarm write with alarm_sel=3 when N_ALARM=2 -> no state change. Disabling channel 1 while ringing -> alarm_ring[1]=0 next edge.
- TWELVE_HOUR_EN: overwrite 00:10:00 -> hour12=12, pm=0. Overwrite 12:00:00 -> hour12=12, pm=1. Overwrite 13:00:00 -> hour12=1, pm=1.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg
// Shared field widths, range limits, the packed time record and the
// field validation helper used by clock_work_multi.
// Time packing is {hour[16:12], min[11:6], sec[5:0]}.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int TIME_W = 17;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  // Out-of-range fields are forced to zero; valid fields pass through untouched.
  function automatic time_t validate_time(input time_t t);
    time_t v;
    v = t;
    if (t.sec > SEC_MAX)   v.sec  = '0;
    if (t.min > MIN_MAX)   v.min  = '0;
    if (t.hour > HOUR_MAX) v.hour = '0;
    return v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides the system clock down to one tick per TICK_DIV cycles.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clear - restart the count from zero (used on time overwrite)
//   tick  - high during the last cycle of each TICK_DIV-cycle period
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/clock_work_multi.sv
// clock_work_multi
// 24-hour timekeeping core running from the system clock through an internal
// prescaler, with synchronous time overwrite, N_ALARM alarm channels with
// sticky ring flags, and second/day strobes.
// Optional feature macro: TWELVE_HOUR_EN adds registered hour12/pm outputs.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   time_ow      - load time_in (validated) and restart the prescaler
//   time_in      - {hour, min, sec} to load
//   alarm_wr     - write channel alarm_sel with alarm_in / alarm_en_in
//   alarm_sel    - alarm channel index (indices >= N_ALARM are ignored)
//   alarm_in     - alarm time, same packing as time_in
//   alarm_en_in  - enable bit stored with alarm_in
//   alarm_ack    - per-channel ring clear
//   time_out     - current time (registered)
//   sec_tick     - one-cycle pulse when time_out shows an incremented second
//   day_pulse    - one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
//   alarm_ring   - sticky per-channel ring flags
//   hour12, pm   - 12-hour view of time_out (TWELVE_HOUR_EN only)
module clock_work_multi
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int N_ALARM  = 2,
  localparam int SEL_W   = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               time_ow,
  input  logic [16:0]        time_in,
  input  logic               alarm_wr,
  input  logic [SEL_W-1:0]   alarm_sel,
  input  logic [16:0]        alarm_in,
  input  logic               alarm_en_in,
  input  logic [N_ALARM-1:0] alarm_ack,
  output logic [16:0]        time_out,
  output logic               sec_tick,
  output logic               day_pulse,
  output logic [N_ALARM-1:0] alarm_ring
`ifdef TWELVE_HOUR_EN
  ,
  output logic [3:0]         hour12,
  output logic               pm
`endif
);

  time_t              cur_time;
  time_t              next_time;
  time_t              alarm_time [N_ALARM];
  logic [N_ALARM-1:0] alarm_en;
  logic [N_ALARM-1:0] wr_hit;
  logic [N_ALARM-1:0] match;
  logic               tick;
  logic               inc;
  logic               rollover;
  logic               time_change;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (time_ow),
    .tick  (tick)
  );

  // Overwrite beats a coincident tick, so an increment only happens on a
  // tick cycle without time_ow.
  assign inc         = tick && !time_ow;
  assign time_change = tick || time_ow;
  assign rollover    = (cur_time.sec == SEC_MAX) && (cur_time.min == MIN_MAX) &&
                       (cur_time.hour == HOUR_MAX);

  // Next-time value: validated load, ripple-carry increment, or hold.
  always_comb begin
    next_time = cur_time;
    if (time_ow) begin
      next_time = validate_time(time_t'(time_in));
    end else if (tick) begin
      if (cur_time.sec == SEC_MAX) begin
        next_time.sec = '0;
        if (cur_time.min == MIN_MAX) begin
          next_time.min = '0;
          if (cur_time.hour == HOUR_MAX) begin
            next_time.hour = '0;
          end else begin
            next_time.hour = cur_time.hour + 5'd1;
          end
        end else begin
          next_time.min = cur_time.min + 6'd1;
        end
      end else begin
        next_time.sec = cur_time.sec + 6'd1;
      end
    end
  end

  // Channel decode and match against the pre-write alarm registers.
  always_comb begin
    wr_hit = '0;
    match  = '0;
    for (int k = 0; k < N_ALARM; k++) begin
      if (alarm_wr && (32'(alarm_sel) == k)) wr_hit[k] = 1'b1;
      if (time_change && alarm_en[k] && (next_time == alarm_time[k])) match[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_time  <= '0;
      sec_tick  <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      cur_time  <= next_time;
      sec_tick  <= inc;
      day_pulse <= inc && rollover;
    end
  end

  // Alarm registers and ring flags. A fresh match outranks both the
  // disable-write clear and the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_ALARM; k++) alarm_time[k] <= '0;
      alarm_en   <= '0;
      alarm_ring <= '0;
    end else begin
      for (int k = 0; k < N_ALARM; k++) begin
        if (wr_hit[k]) begin
          alarm_time[k] <= validate_time(time_t'(alarm_in));
          alarm_en[k]   <= alarm_en_in;
        end
        if (match[k]) begin
          alarm_ring[k] <= 1'b1;
        end else if ((wr_hit[k] && !alarm_en_in) || alarm_ack[k]) begin
          alarm_ring[k] <= 1'b0;
        end
      end
    end
  end

  assign time_out = cur_time;

`ifdef TWELVE_HOUR_EN
  function automatic logic [3:0] to_hour12(input logic [HOUR_W-1:0] h);
    logic [HOUR_W-1:0] d;
    d = h - 5'd12;
    if (h == 5'd0)       return 4'd12;
    else if (h <= 5'd12) return h[3:0];
    else                 return d[3:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      hour12 <= 4'd12;
      pm     <= 1'b0;
    end else begin
      hour12 <= to_hour12(next_time.hour);
      pm     <= (next_time.hour >= 5'd12);
    end
  end
`endif

endmodule

// File: tb/tb_clock_work_multi.sv
// tb_clock_work_multi
// Directed bench for clock_work_multi with TICK_DIV=4 and N_ALARM=3
// (three channels give a 2-bit alarm_sel so index 3 is a real out-of-range
// value). With TWELVE_HOUR_EN defined the hour12/pm outputs are also checked.
module tb_clock_work_multi;

  localparam int TICK_DIV = 4;
  localparam int N_ALARM  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               time_ow;
  logic [16:0]        time_in;
  logic               alarm_wr;
  logic [1:0]         alarm_sel;
  logic [16:0]        alarm_in;
  logic               alarm_en_in;
  logic [N_ALARM-1:0] alarm_ack;
  logic [16:0]        time_out;
  logic               sec_tick;
  logic               day_pulse;
  logic [N_ALARM-1:0] alarm_ring;
`ifdef TWELVE_HOUR_EN
  logic [3:0]         hour12;
  logic               pm;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  clock_work_multi #(
    .TICK_DIV (TICK_DIV),
    .N_ALARM  (N_ALARM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .time_ow     (time_ow),
    .time_in     (time_in),
    .alarm_wr    (alarm_wr),
    .alarm_sel   (alarm_sel),
    .alarm_in    (alarm_in),
    .alarm_en_in (alarm_en_in),
    .alarm_ack   (alarm_ack),
    .time_out    (time_out),
    .sec_tick    (sec_tick),
    .day_pulse   (day_pulse),
    .alarm_ring  (alarm_ring)
`ifdef TWELVE_HOUR_EN
    ,
    .hour12      (hour12),
    .pm          (pm)
`endif
  );

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Hold time_ow for exactly one edge.
  task automatic overwrite(input logic [16:0] t);
    time_ow = 1'b1;
    time_in = t;
    applyStimulus(1);
    time_ow = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    time_ow     = 1'b0;
    time_in     = '0;
    alarm_wr    = 1'b0;
    alarm_sel   = '0;
    alarm_in    = '0;
    alarm_en_in = 1'b0;
    alarm_ack   = '0;

    applyStimulus(2);
    checkOutput("rst_time", 32'(time_out), 32'h0);
    checkOutput("rst_tick", 32'(sec_tick), 32'h0);
    checkOutput("rst_day", 32'(day_pulse), 32'h0);
    checkOutput("rst_ring", 32'(alarm_ring), 32'h0);
`ifdef TWELVE_HOUR_EN
    checkOutput("rst_h12", 32'(hour12), 32'd12);
    checkOutput("rst_pm", 32'(pm), 32'h0);
`endif

    // First second arrives on the 4th edge after reset release.
    rst = 1'b0;
    applyStimulus(3);
    checkOutput("pre_tick_time", 32'(time_out), 32'h0);
    checkOutput("pre_tick_flag", 32'(sec_tick), 32'h0);
    applyStimulus(1);
    checkOutput("tick1_time", 32'(time_out), 32'h00001);
    checkOutput("tick1_flag", 32'(sec_tick), 32'h1);
    checkOutput("tick1_ring", 32'(alarm_ring), 32'h0);
    applyStimulus(1);
    checkOutput("tick1_flag_drop", 32'(sec_tick), 32'h0);

    // Day rollover from 23:59:59.
    overwrite(17'b10111_111011_111011);
    checkOutput("ow_2359_time", 32'(time_out), 32'h17EFB);
    checkOutput("ow_2359_tick", 32'(sec_tick), 32'h0);
`ifdef TWELVE_HOUR_EN
    checkOutput("h12_23", 32'(hour12), 32'd11);
    checkOutput("pm_23", 32'(pm), 32'h1);
`endif
    applyStimulus(3);
    checkOutput("pre_roll_day", 32'(day_pulse), 32'h0);
    applyStimulus(1);
    checkOutput("roll_time", 32'(time_out), 32'h0);
    checkOutput("roll_tick", 32'(sec_tick), 32'h1);
    checkOutput("roll_day", 32'(day_pulse), 32'h1);
    applyStimulus(1);
    checkOutput("roll_day_drop", 32'(day_pulse), 32'h0);

    // Invalid minute field is zeroed: 23:60:05 -> 23:00:05.
    overwrite(17'b10111_111100_000101);
    checkOutput("ow_min60", 32'(time_out), 32'h17005);

    // Overwrite on a tick cycle: no increment, full period until next tick.
    applyStimulus(3);
    checkOutput("hold_before_tick", 32'(time_out), 32'h17005);
    overwrite(17'h0000A);
    checkOutput("ow_on_tick_time", 32'(time_out), 32'h0000A);
    checkOutput("ow_on_tick_flag", 32'(sec_tick), 32'h0);
    checkOutput("ow_on_tick_day", 32'(day_pulse), 32'h0);
    applyStimulus(3);
    checkOutput("ow_restart_hold", 32'(time_out), 32'h0000A);
    applyStimulus(1);
    checkOutput("ow_restart_tick", 32'(time_out), 32'h0000B);
    checkOutput("ow_restart_flag", 32'(sec_tick), 32'h1);

    // Alarm channel 1 at 00:00:02, enabled.
    alarm_wr = 1'b1; alarm_sel = 2'd1; alarm_in = 17'h00002; alarm_en_in = 1'b1;
    applyStimulus(1);
    alarm_wr = 1'b0;
    overwrite(17'h00000);
    checkOutput("al_start_ring", 32'(alarm_ring), 32'h0);
    applyStimulus(4);
    checkOutput("al_t1_ring", 32'(alarm_ring), 32'h0);
    applyStimulus(4);
    checkOutput("al_t2_time", 32'(time_out), 32'h00002);
    checkOutput("al_t2_ring", 32'(alarm_ring), 32'b010);
    applyStimulus(4);
    checkOutput("al_t3_hold", 32'(alarm_ring), 32'b010);

    // Ack coincident with a fresh match: set wins.
    alarm_ack = 3'b010;
    overwrite(17'h00002);
    alarm_ack = '0;
    checkOutput("ack_vs_set", 32'(alarm_ring), 32'b010);
    alarm_ack = 3'b010;
    applyStimulus(1);
    alarm_ack = '0;
    checkOutput("lone_ack", 32'(alarm_ring), 32'b000);

    // Out-of-range channel index is ignored.
    alarm_wr = 1'b1; alarm_sel = 2'd3; alarm_in = 17'h00007; alarm_en_in = 1'b1;
    applyStimulus(1);
    alarm_wr = 1'b0;
    overwrite(17'h00007);
    checkOutput("bad_sel_ring", 32'(alarm_ring), 32'b000);

    // Disabling a ringing channel clears its flag on the write edge.
    overwrite(17'h00002);
    checkOutput("reset_ring_again", 32'(alarm_ring), 32'b010);
    alarm_wr = 1'b1; alarm_sel = 2'd1; alarm_in = 17'h00002; alarm_en_in = 1'b0;
    applyStimulus(1);
    alarm_wr = 1'b0;
    checkOutput("disable_clear", 32'(alarm_ring), 32'b000);

    // Channel 0 with invalid hour 25:02:03 stores 00:02:03.
    alarm_wr = 1'b1; alarm_sel = 2'd0; alarm_in = 17'h19083; alarm_en_in = 1'b1;
    applyStimulus(1);
    alarm_wr = 1'b0;
    overwrite(17'h00083);
    checkOutput("ch0_valid_ring", 32'(alarm_ring), 32'b001);

    // Reset mid-second clears ring and discards the partial second.
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("rst2_time", 32'(time_out), 32'h0);
    checkOutput("rst2_ring", 32'(alarm_ring), 32'h0);
    applyStimulus(3);
    checkOutput("rst2_hold", 32'(time_out), 32'h0);
    applyStimulus(1);
    checkOutput("rst2_tick", 32'(time_out), 32'h00001);

`ifdef TWELVE_HOUR_EN
    overwrite(17'h00280);
    checkOutput("h12_0010", 32'(hour12), 32'd12);
    checkOutput("pm_0010", 32'(pm), 32'h0);
    overwrite(17'h0C000);
    checkOutput("h12_1200", 32'(hour12), 32'd12);
    checkOutput("pm_1200", 32'(pm), 32'h1);
    overwrite(17'h0D000);
    checkOutput("h12_1300", 32'(hour12), 32'd1);
    checkOutput("pm_1300", 32'(pm), 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
